ex_commit_ctrl: RTL and testbench

- Exception/ERTN commit sequencer between the WB stage and the CSR file.
- Prioritises the WB-stage exception sources and the pending interrupt, then drives the CSR exception-commit inputs (wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush).
- Runs a fixed-length pipeline flush, then issues a single fetch redirect to EENTRY or ERA.
- Back-pressures WB while a sequence is in flight.

---
 rtl/ex_commit_ctrl_if.sv | 49 ++++
 rtl/ex_commit_ctrl.sv | 152 +++++++++++++++
 tb/tb_ex_commit_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_commit_ctrl_if.sv
// ex_commit_ctrl_if
//   Groups the WB-stage exception sources, the CSR-side values and the
//   controller's commit/flush/redirect outputs into one bundle.
// Modports:
//   master : WB stage / CSR file side. Drives ws_*, has_int and csr_*.
//            Receives the commit, flush, redirect and stall outputs.
//   slave  : the ex_commit_ctrl sequencer (the opposite directions).
interface ex_commit_ctrl_if;
    // WB stage
    logic        ws_valid;
    logic [31:0] ws_pc;
    logic [31:0] ws_vaddr;
    logic        ws_ex_adef;
    logic        ws_ex_ine;
    logic        ws_ex_sys;
    logic        ws_ex_brk;
    logic        ws_ex_ale;
    logic        ws_ertn;
    logic        ws_stall;
    // CSR file
    logic        has_int;
    logic [31:0] csr_eentry;
    logic [31:0] csr_era;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    logic        ertn_flush;
    // Pipeline control
    logic        flush_o;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] ex_count;

    modport master (
        output ws_valid, ws_pc, ws_vaddr, ws_ex_adef, ws_ex_ine, ws_ex_sys, ws_ex_brk,
               ws_ex_ale, ws_ertn, has_int, csr_eentry, csr_era,
        input  ws_stall, wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
               flush_o, redirect_valid, redirect_pc, ex_count
    );

    modport slave (
        input  ws_valid, ws_pc, ws_vaddr, ws_ex_adef, ws_ex_ine, ws_ex_sys, ws_ex_brk,
               ws_ex_ale, ws_ertn, has_int, csr_eentry, csr_era,
        output ws_stall, wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
               flush_o, redirect_valid, redirect_pc, ex_count
    );
endinterface

// File: rtl/ex_commit_ctrl.sv
// ex_commit_ctrl
//   Exception / ERTN commit sequencer between the WB stage and the CSR file.
//   Picks the highest-priority exception source (interrupt first), pulses the
//   CSR commit inputs for one cycle, holds flush_o for FLUSH_CYCLES cycles and
//   then issues one fetch redirect to EENTRY (exception) or ERA (ERTN).
//   WB is stalled for the whole sequence.
// Parameters:
//   FLUSH_CYCLES : cycles flush_o stays high, 1..15.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : ex_commit_ctrl_if.slave (WB inputs, CSR values, commit/flush/redirect outputs)
// Build option:
//   EX_COMMIT_CNT_EN : when defined, ex_count counts committed exceptions
//                      (saturating); otherwise ex_count is tied to 0.
module ex_commit_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic             clk,
    input logic             reset,
    ex_commit_ctrl_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StExc, StErt, StFlush, StRedir} state_e;

    localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        sel_era_q, sel_era_d;
    logic [5:0]  ecode_q, ecode_d;
    logic [8:0]  esub_q, esub_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] vaddr_q, vaddr_d;

    logic        stall;
    logic        trigger;
    logic        has_exc;
    logic [5:0]  exc_code;

    assign stall   = (state_q != StIdle);
    assign trigger = bus.ws_valid && !stall;
    assign has_exc = bus.has_int | bus.ws_ex_adef | bus.ws_ex_ine | bus.ws_ex_sys |
                     bus.ws_ex_brk | bus.ws_ex_ale;

    // Fixed priority, interrupt highest.
    always_comb begin
        exc_code = 6'h00;
        if (bus.has_int)         exc_code = 6'h00;
        else if (bus.ws_ex_adef) exc_code = 6'h08;
        else if (bus.ws_ex_ine)  exc_code = 6'h0D;
        else if (bus.ws_ex_sys)  exc_code = 6'h0B;
        else if (bus.ws_ex_brk)  exc_code = 6'h0C;
        else if (bus.ws_ex_ale)  exc_code = 6'h09;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_era_d = sel_era_q;
        ecode_d   = ecode_q;
        esub_d    = esub_q;
        pc_d      = pc_q;
        vaddr_d   = vaddr_q;
        unique case (state_q)
            StIdle: begin
                if (trigger) begin
                    // An exception in the same cycle as ERTN wins.
                    if (has_exc) begin
                        ecode_d = exc_code;
                        esub_d  = 9'd0;
                        pc_d    = bus.ws_pc;
                        vaddr_d = bus.ws_vaddr;
                        state_d = StExc;
                    end else if (bus.ws_ertn) begin
                        state_d = StErt;
                    end
                end
            end
            StExc: begin
                cnt_d     = FlushLoad;
                sel_era_d = 1'b0;
                state_d   = StFlush;
            end
            StErt: begin
                cnt_d     = FlushLoad;
                sel_era_d = 1'b1;
                state_d   = StFlush;
            end
            StFlush: begin
                if (cnt_q == 4'd0) begin
                    state_d = StRedir;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StRedir: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            sel_era_q <= 1'b0;
            ecode_q   <= 6'd0;
            esub_q    <= 9'd0;
            pc_q      <= 32'd0;
            vaddr_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_era_q <= sel_era_d;
            ecode_q   <= ecode_d;
            esub_q    <= esub_d;
            pc_q      <= pc_d;
            vaddr_q   <= vaddr_d;
        end
    end

    assign bus.ws_stall       = stall;
    assign bus.wb_ex          = (state_q == StExc);
    assign bus.ertn_flush     = (state_q == StErt);
    assign bus.flush_o        = (state_q == StFlush);
    assign bus.redirect_valid = (state_q == StRedir);
    // Read live in REDIR so CSR writes caused by the commit pulse are seen.
    assign bus.redirect_pc    = (state_q == StRedir) ? (sel_era_q ? bus.csr_era : bus.csr_eentry)
                                                     : 32'd0;
    // Held between exceptions; the CSR file qualifies them with wb_ex.
    assign bus.wb_ecode       = ecode_q;
    assign bus.wb_esubcode    = esub_q;
    assign bus.wb_pc          = pc_q;
    assign bus.wb_vaddr       = vaddr_q;

`ifdef EX_COMMIT_CNT_EN
    logic [31:0] ex_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_count_q <= 32'd0;
        end else if (state_q == StExc && ex_count_q != 32'hFFFF_FFFF) begin
            ex_count_q <= ex_count_q + 32'd1;
        end
    end

    assign bus.ex_count = ex_count_q;
`else
    assign bus.ex_count = 32'd0;
`endif

endmodule

// File: tb/tb_ex_commit_ctrl.sv
module tb_ex_commit_ctrl;

    localparam int F = 2;

    // Exception priority table, highest first: int, adef, ine, sys, brk, ale.
    localparam logic [5:0] CODE_TBL [6] = '{6'h00, 6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};

    localparam logic [5:0] FL_INT = 6'b100000;
    localparam logic [5:0] FL_INE = 6'b001000;
    localparam logic [5:0] FL_SYS = 6'b000100;
    localparam logic [5:0] FL_BRK = 6'b000010;
    localparam logic [5:0] FL_ALE = 6'b000001;

    typedef struct {
        int          cyc;      // cycle in which the commit pulse is due
        bit          is_ertn;
        logic [5:0]  ecode;
        logic [31:0] pc;
        logic [31:0] vaddr;
        logic [31:0] target;
    } rec_t;

    logic clk;
    logic reset;
    ex_commit_ctrl_if bus ();

    ex_commit_ctrl #(.FLUSH_CYCLES(F)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   free_at = 0;
    bit   mon_en = 1'b0;
    rec_t cq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, got, want);
        end
    endtask

    function automatic logic [5:0] exp_code(input logic [5:0] fl);
        logic [5:0] c;
        bit         found;
        c = 6'd0;
        found = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!found && fl[5-i]) begin
                c = CODE_TBL[i];
                found = 1'b1;
            end
        end
        return c;
    endfunction

    // One WB cycle of stimulus; the model decides acceptance and queues the commit.
    task automatic drive(input logic v, input logic [5:0] fl, input logic ertn,
                         input logic [31:0] pc, input logic [31:0] va,
                         input logic [31:0] ee, input logic [31:0] era, output bit acc);
        rec_t r;
        acc = v && (cyc >= free_at) && (fl != 6'd0 || ertn);
        if (acc) begin
            bus.csr_eentry = ee;
            bus.csr_era    = era;
            r.cyc     = cyc + 1;
            r.is_ertn = (fl == 6'd0);
            r.ecode   = exp_code(fl);
            r.pc      = pc;
            r.vaddr   = va;
            r.target  = r.is_ertn ? era : ee;
            cq.push_back(r);
            free_at = cyc + F + 3;
        end
        bus.ws_valid = v;
        {bus.has_int, bus.ws_ex_adef, bus.ws_ex_ine, bus.ws_ex_sys, bus.ws_ex_brk,
         bus.ws_ex_ale} = fl;
        bus.ws_ertn  = ertn;
        bus.ws_pc    = pc;
        bus.ws_vaddr = va;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive(1'b0, 6'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, acc);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        bus.ws_valid = 1'b0;
        {bus.has_int, bus.ws_ex_adef, bus.ws_ex_ine, bus.ws_ex_sys, bus.ws_ex_brk,
         bus.ws_ex_ale, bus.ws_ertn} = 7'd0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        free_at = cyc;
    endtask

    // Monitor: pops the scoreboard when a commit is due and checks every output each cycle.
    int          fl_lo = 1, fl_hi = 0, redir_at = -1, busy_lo = 1;
    logic [31:0] tgt = 32'd0;
    logic [5:0]  h_ecode = 6'd0;
    logic [31:0] h_pc = 32'd0, h_va = 32'd0;
    logic [31:0] cnt_exp = 32'd0;

    always @(negedge clk) begin
        rec_t r;
        logic exp_ex, exp_ert;
        if (mon_en) begin
            exp_ex  = 1'b0;
            exp_ert = 1'b0;
            if (cq.size() > 0 && cq[0].cyc == cyc) begin
                r = cq.pop_front();
                exp_ex  = !r.is_ertn;
                exp_ert = r.is_ertn;
                if (!r.is_ertn) begin
                    h_ecode = r.ecode;
                    h_pc    = r.pc;
                    h_va    = r.vaddr;
                end
                fl_lo    = cyc + 1;
                fl_hi    = cyc + F;
                redir_at = cyc + F + 1;
                busy_lo  = cyc;
                tgt      = r.target;
            end
            check("ctrl{ex,ertn,flush,redir,stall}",
                  {bus.wb_ex, bus.ertn_flush, bus.flush_o, bus.redirect_valid, bus.ws_stall},
                  {exp_ex, exp_ert, (cyc >= fl_lo && cyc <= fl_hi), (cyc == redir_at),
                   (cyc >= busy_lo && cyc <= redir_at)});
            check("wb_fields", {bus.wb_ecode, bus.wb_esubcode, bus.wb_pc, bus.wb_vaddr},
                  {h_ecode, 9'd0, h_pc, h_va});
            check("redirect_pc", bus.redirect_pc, (cyc == redir_at) ? tgt : 32'd0);
            check("ex_count", bus.ex_count, cnt_exp);
`ifdef EX_COMMIT_CNT_EN
            if (exp_ex) cnt_exp = cnt_exp + 32'd1;
`endif
            if (reset) begin
                cq.delete();
                fl_lo = 1; fl_hi = 0; redir_at = -1; busy_lo = 1;
                h_ecode = 6'd0; h_pc = 32'd0; h_va = 32'd0;
                cnt_exp = 32'd0;
            end
        end
    end

    initial begin
        bit acc;
        reset = 1'b1;
        bus.ws_valid = 1'b0;
        bus.ws_pc = 32'd0;
        bus.ws_vaddr = 32'd0;
        {bus.has_int, bus.ws_ex_adef, bus.ws_ex_ine, bus.ws_ex_sys, bus.ws_ex_brk,
         bus.ws_ex_ale, bus.ws_ertn} = 7'd0;
        bus.csr_eentry = 32'd0;
        bus.csr_era = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        do_reset(1);
        check("reset_state",
              {bus.wb_ex, bus.ertn_flush, bus.flush_o, bus.redirect_valid, bus.ws_stall,
               bus.wb_ecode, bus.wb_esubcode, bus.wb_pc, bus.wb_vaddr, bus.redirect_pc,
               bus.ex_count}, 128'd0);

        // Syscall
        drive(1'b1, FL_SYS, 1'b0, 32'h1c000100, 32'h0, 32'h1c008000, 32'h0, acc);
        idle(F + 4);
        // Interrupt beats ale/brk; then brk beats ale
        drive(1'b1, FL_INT | FL_BRK | FL_ALE, 1'b0, 32'h1c000200, 32'h3, 32'h1c008000, 32'h0, acc);
        idle(F + 4);
        drive(1'b1, FL_BRK | FL_ALE, 1'b0, 32'h1c000200, 32'h3, 32'h1c008000, 32'h0, acc);
        idle(F + 4);
        // ERTN alone, then ERTN with ine
        drive(1'b1, 6'd0, 1'b1, 32'h1c000300, 32'h0, 32'h1c008000, 32'h1c000204, acc);
        idle(F + 4);
        drive(1'b1, FL_INE, 1'b1, 32'h1c000304, 32'h44, 32'h1c008000, 32'h1c000204, acc);
        idle(F + 4);
        // has_int without ws_valid is not taken
        drive(1'b0, FL_INT, 1'b0, 32'h1c000400, 32'h0, 32'h1c008000, 32'h0, acc);
        idle(F + 4);
        // Second trigger held by WB during the flush
        drive(1'b1, FL_SYS, 1'b0, 32'h1c000500, 32'h0, 32'h1c009000, 32'h0, acc);
        idle(1);
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++)
            drive(1'b1, FL_BRK, 1'b0, 32'h1c000504, 32'h8, 32'h1c00a000, 32'h0, acc);
        idle(F + 4);
        // Reset during FLUSH, then a fresh trigger
        drive(1'b1, FL_ALE, 1'b0, 32'h1c000600, 32'h5, 32'h1c00b000, 32'h0, acc);
        idle(2);
        do_reset(1);
        idle(F + 3);
        drive(1'b1, FL_SYS, 1'b0, 32'h1c000700, 32'h0, 32'h1c00c000, 32'h0, acc);
        idle(F + 4);
        // Counter: 3 exceptions and 1 ERTN after a reset
        do_reset(1);
        drive(1'b1, FL_SYS, 1'b0, 32'h100, 32'h0, 32'h2000, 32'h3000, acc);
        idle(F + 3);
        drive(1'b1, FL_BRK, 1'b0, 32'h104, 32'h0, 32'h2000, 32'h3000, acc);
        idle(F + 3);
        drive(1'b1, 6'd0, 1'b1, 32'h108, 32'h0, 32'h2000, 32'h3000, acc);
        idle(F + 3);
        drive(1'b1, FL_INE, 1'b0, 32'h10c, 32'h0, 32'h2000, 32'h3000, acc);
        idle(F + 3);
`ifdef EX_COMMIT_CNT_EN
        check("ex_count_3exc_1ertn", bus.ex_count, 32'd3);
`else
        check("ex_count_disabled", bus.ex_count, 32'd0);
`endif

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [5:0] fl;
            for (int b = 0; b < 6; b++) fl[b] = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 60) == 0) begin
                do_reset($urandom_range(1, 2));
            end else begin
                drive($urandom_range(0, 3) != 0, fl, $urandom_range(0, 3) == 0,
                      $urandom, $urandom, $urandom, $urandom, acc);
            end
        end
        idle(F + 6);
        check("scoreboard_drained", 128'(cq.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
